// File: rtl/vid_in_pkg.sv
// Shared types and constants for the video input monitor.
package vid_in_pkg;

    typedef logic [11:0] cnt12_t;

    typedef struct packed {
        cnt12_t h_total;
        cnt12_t h_active;
        cnt12_t v_total;
        cnt12_t v_active;
    } meas_t;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam cnt12_t CNT_MAX        = 12'hFFF;
    localparam cnt12_t REF_H_TOTAL    = 12'd800;
    localparam cnt12_t REF_H_ACTIVE   = 12'd640;
    localparam cnt12_t REF_V_TOTAL    = 12'd525;
    localparam cnt12_t REF_V_ACTIVE   = 12'd480;

    // Counters stick at full scale instead of wrapping.
    function automatic cnt12_t sat_inc(input cnt12_t v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/vid_edge_sync.sv
// Two-stage input register with sync polarity normalisation and edge pulses.
module vid_edge_sync #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_vid,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [23:0] rgb,
    output logic        de_s1_r,
    output logic [23:0] rgb_s1_r,
    output logic        hs_rise_s,
    output logic        vs_rise_s,
    output logic        de_rise_s,
    output logic        de_fall_s
);

    logic hs_s1_r, vs_s1_r;
    logic hs_s2_r, vs_s2_r, de_s2_r;

    // Stage registers hold syncs already converted to active-high.
    always_ff @(posedge clk_vid) begin
        if (rst) begin
            hs_s1_r  <= 1'b0;
            vs_s1_r  <= 1'b0;
            de_s1_r  <= 1'b0;
            rgb_s1_r <= 24'h000000;
            hs_s2_r  <= 1'b0;
            vs_s2_r  <= 1'b0;
            de_s2_r  <= 1'b0;
        end else begin
            hs_s1_r  <= hs ^ SYNC_ACTIVE_LOW;
            vs_s1_r  <= vs ^ SYNC_ACTIVE_LOW;
            de_s1_r  <= de;
            rgb_s1_r <= rgb;
            hs_s2_r  <= hs_s1_r;
            vs_s2_r  <= vs_s1_r;
            de_s2_r  <= de_s1_r;
        end
    end

    assign hs_rise_s = hs_s1_r & ~hs_s2_r;
    assign vs_rise_s = vs_s1_r & ~vs_s2_r;
    assign de_rise_s = de_s1_r & ~de_s2_r;
    assign de_fall_s = ~de_s1_r & de_s2_r;

endmodule

// File: rtl/vid_in_monitor.sv
// Receive-side video timing monitor: pixel coordinates, frame measurement,
// lock tracking and per-frame pixel checksum.
module vid_in_monitor
    import vid_in_pkg::*;
#(
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter int unsigned TIMEOUT         = 2000000
) (
    input  logic        clk_vid,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [23:0] rgb,
    output logic        px_valid,
    output logic [23:0] px_rgb,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        sof,
    output logic        eol,
    output logic [11:0] h_total,
    output logic [11:0] h_active,
    output logic [11:0] v_total,
    output logic [11:0] v_active,
    output logic [31:0] frame_sum,
    output logic        locked,
    output logic        meas_stb
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_FRAMES);

    logic        de_s1_r, hs_rise_s, vs_rise_s, de_rise_s, de_fall_s;
    logic [23:0] rgb_s1_r;

    vid_edge_sync #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_sync (
        .clk_vid   (clk_vid),
        .rst       (rst),
        .hs        (hs),
        .vs        (vs),
        .de        (de),
        .rgb       (rgb),
        .de_s1_r   (de_s1_r),
        .rgb_s1_r  (rgb_s1_r),
        .hs_rise_s (hs_rise_s),
        .vs_rise_s (vs_rise_s),
        .de_rise_s (de_rise_s),
        .de_fall_s (de_fall_s)
    );

    cnt12_t      next_x_s, next_y_s;
    logic        vs_seen_r, y_pending_r;

    // Coordinates of the pixel currently in stage 1.
    always_comb begin
        next_x_s = px_x;
        next_y_s = px_y;
        if (de_s1_r) begin
            next_x_s = de_rise_s ? 12'd0 : sat_inc(px_x);
        end else begin
            next_x_s = px_x;
        end
        if (de_rise_s) begin
            if (vs_rise_s || y_pending_r || !vs_seen_r) begin
                next_y_s = 12'd0;
            end else begin
                next_y_s = sat_inc(px_y);
            end
        end else begin
            next_y_s = px_y;
        end
    end

    // Pixel output stage; eol looks one sample ahead via the raw de input.
    always_ff @(posedge clk_vid) begin
        if (rst) begin
            px_valid    <= 1'b0;
            px_rgb      <= 24'h000000;
            px_x        <= 12'd0;
            px_y        <= 12'd0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            vs_seen_r   <= 1'b0;
            y_pending_r <= 1'b0;
        end else begin
            px_valid    <= de_s1_r;
            px_rgb      <= rgb_s1_r;
            px_x        <= next_x_s;
            px_y        <= next_y_s;
            sof         <= de_s1_r && (next_x_s == 12'd0) && (next_y_s == 12'd0);
            eol         <= de_s1_r && !de;
            vs_seen_r   <= vs_seen_r | vs_rise_s;
            y_pending_r <= de_rise_s ? 1'b0 : (y_pending_r | vs_rise_s);
        end
    end

    cnt12_t        line_cnt_r, de_cnt_r, hs_cnt_r, act_cnt_r;
    cnt12_t        h_total_work_r, h_active_work_r;
    logic [31:0]   sum_acc_r;
    logic [TW-1:0] to_cnt_r;

    // Line, frame and checksum accumulation; an hs edge coincident with vs
    // belongs to the closing frame, a pixel coincident with vs to the new one.
    always_ff @(posedge clk_vid) begin
        if (rst) begin
            line_cnt_r      <= 12'd0;
            de_cnt_r        <= 12'd0;
            hs_cnt_r        <= 12'd0;
            act_cnt_r       <= 12'd0;
            h_total_work_r  <= 12'd0;
            h_active_work_r <= 12'd0;
            sum_acc_r       <= 32'd0;
            to_cnt_r        <= '0;
        end else begin
            line_cnt_r      <= hs_rise_s ? 12'd1 : sat_inc(line_cnt_r);
            h_total_work_r  <= hs_rise_s ? line_cnt_r : h_total_work_r;
            de_cnt_r        <= de_rise_s ? 12'd1 : (de_s1_r ? sat_inc(de_cnt_r) : de_cnt_r);
            h_active_work_r <= de_fall_s ? de_cnt_r : h_active_work_r;
            if (vs_rise_s) begin
                hs_cnt_r  <= 12'd0;
                act_cnt_r <= de_rise_s ? 12'd1 : 12'd0;
                sum_acc_r <= de_s1_r ? {8'h00, rgb_s1_r} : 32'd0;
                to_cnt_r  <= '0;
            end else begin
                hs_cnt_r  <= hs_rise_s ? sat_inc(hs_cnt_r) : hs_cnt_r;
                act_cnt_r <= de_rise_s ? sat_inc(act_cnt_r) : act_cnt_r;
                sum_acc_r <= de_s1_r ? sum_acc_r + {8'h00, rgb_s1_r} : sum_acc_r;
                to_cnt_r  <= (to_cnt_r == TO_LIMIT) ? to_cnt_r : to_cnt_r + TW'(1);
            end
        end
    end

    meas_t      meas_new_s, meas_r;
    mon_state_t state_r;
    logic [3:0] match_cnt_r, match_next_s;
    logic       prev_valid_r, same_s, timeout_s;

    // Values of the frame closing in this cycle, including same-cycle edges.
    always_comb begin
        meas_new_s.h_total  = hs_rise_s ? line_cnt_r : h_total_work_r;
        meas_new_s.h_active = de_fall_s ? de_cnt_r : h_active_work_r;
        meas_new_s.v_total  = hs_rise_s ? sat_inc(hs_cnt_r) : hs_cnt_r;
        meas_new_s.v_active = act_cnt_r;
        same_s              = prev_valid_r && (meas_new_s == meas_r);
        match_next_s        = match_cnt_r + 4'd1;
        timeout_s           = (to_cnt_r == TO_LIMIT);
    end

    // Lock FSM: publish at each frame boundary, count repeats, drop on timeout.
    always_ff @(posedge clk_vid) begin
        if (rst) begin
            state_r      <= SEEK;
            match_cnt_r  <= 4'd0;
            prev_valid_r <= 1'b0;
            meas_r       <= '0;
            frame_sum    <= 32'd0;
            locked       <= 1'b0;
            meas_stb     <= 1'b0;
        end else begin
            meas_stb <= 1'b0;
            if (vs_rise_s) begin
                case (state_r)
                    SEEK: begin
                        state_r      <= MEASURE;
                        match_cnt_r  <= 4'd0;
                        prev_valid_r <= 1'b0;
                    end
                    MEASURE, LOCKED: begin
                        meas_stb     <= 1'b1;
                        meas_r       <= meas_new_s;
                        frame_sum    <= sum_acc_r;
                        prev_valid_r <= 1'b1;
                        if (!same_s) begin
                            state_r     <= MEASURE;
                            locked      <= 1'b0;
                            match_cnt_r <= 4'd0;
                        end else if (state_r == MEASURE) begin
                            match_cnt_r <= match_next_s;
                            if (match_next_s == LOCK_N) begin
                                state_r <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                state_r <= MEASURE;
                            end
                        end else begin
                            state_r <= LOCKED;
                        end
                    end
                    default: begin
                        state_r     <= SEEK;
                        locked      <= 1'b0;
                        match_cnt_r <= 4'd0;
                    end
                endcase
            end else if (timeout_s) begin
                state_r      <= SEEK;
                locked       <= 1'b0;
                match_cnt_r  <= 4'd0;
                prev_valid_r <= 1'b0;
                meas_r       <= '0;
                frame_sum    <= 32'd0;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign h_total  = meas_r.h_total;
    assign h_active = meas_r.h_active;
    assign v_total  = meas_r.v_total;
    assign v_active = meas_r.v_active;

endmodule

// File: tb/tb_vid_in_monitor.sv
// Randomised bench for vid_in_monitor: frame generator plus frame-level model,
// driving an active-low-sync and an active-high-sync instance in parallel.
module tb_vid_in_monitor;
    import vid_in_pkg::*;

    localparam int LOCK_N = 2;
    localparam int TO     = 300;
    localparam int HSTART = 3;
    localparam int VSTART = 2;

    logic clk_vid = 1'b0;
    always #5 clk_vid = ~clk_vid;

    logic        rst = 1'b1, hs_a = 1'b1, vs_a = 1'b1, hs_b = 1'b0, vs_b = 1'b0, de = 1'b0;
    logic [23:0] rgb = 24'h000000;

    logic        px_valid_a, sof_a, eol_a, locked_a, meas_stb_a;
    logic [23:0] px_rgb_a;
    logic [11:0] px_x_a, px_y_a, h_total_a, h_active_a, v_total_a, v_active_a;
    logic [31:0] frame_sum_a;
    logic        px_valid_b, sof_b, eol_b, locked_b, meas_stb_b;
    logic [23:0] px_rgb_b;
    logic [11:0] px_x_b, px_y_b, h_total_b, h_active_b, v_total_b, v_active_b;
    logic [31:0] frame_sum_b;

    vid_in_monitor #(.SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LOCK_N), .TIMEOUT(TO)) dut_a (
        .clk_vid(clk_vid), .rst(rst), .hs(hs_a), .vs(vs_a), .de(de), .rgb(rgb),
        .px_valid(px_valid_a), .px_rgb(px_rgb_a), .px_x(px_x_a), .px_y(px_y_a),
        .sof(sof_a), .eol(eol_a), .h_total(h_total_a), .h_active(h_active_a),
        .v_total(v_total_a), .v_active(v_active_a), .frame_sum(frame_sum_a),
        .locked(locked_a), .meas_stb(meas_stb_a));

    vid_in_monitor #(.SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(LOCK_N), .TIMEOUT(TO)) dut_b (
        .clk_vid(clk_vid), .rst(rst), .hs(hs_b), .vs(vs_b), .de(de), .rgb(rgb),
        .px_valid(px_valid_b), .px_rgb(px_rgb_b), .px_x(px_x_b), .px_y(px_y_b),
        .sof(sof_b), .eol(eol_b), .h_total(h_total_b), .h_active(h_active_b),
        .v_total(v_total_b), .v_active(v_active_b), .frame_sum(frame_sum_b),
        .locked(locked_b), .meas_stb(meas_stb_b));

    typedef struct {
        bit          valid, sof, eol, stb, locked, chk_px, chk_meas;
        bit   [23:0] rgb;
        int          x, y, ht, ha, vt, va;
        bit   [31:0] sum;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: lock tracking by frame, published values, last full frame.
    int        m_state, m_match;
    bit        m_has_last, m_locked, m_vs_seen;
    int        last_ht, last_ha, last_vt, last_va;
    int        o_ht, o_ha, o_vt, o_va;
    bit [31:0] o_sum;
    int        f_ht, f_ha, f_vt, f_va;
    bit [31:0] f_sum;
    exp_t      prev_e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t base_e();
        exp_t e;
        e = '{default: 0};
        e.locked = m_locked;
        e.ht = o_ht; e.ha = o_ha; e.vt = o_vt; e.va = o_va;
        e.sum = o_sum;
        return e;
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e = '{default: 0};
        e.chk_px   = 1'b1;
        e.chk_meas = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_match = 0; m_has_last = 1'b0; m_locked = 1'b0; m_vs_seen = 1'b0;
        o_ht = 0; o_ha = 0; o_vt = 0; o_va = 0; o_sum = 32'd0;
    endtask

    task automatic check_all(input exp_t e);
        chk("px_valid", 32'(px_valid_a), 32'(e.valid));
        if (e.valid || e.chk_px) begin
            chk("px_x", 32'(px_x_a), 32'(e.x));
            chk("px_y", 32'(px_y_a), 32'(e.y));
            chk("px_rgb", 32'(px_rgb_a), 32'(e.rgb));
        end
        chk("sof", 32'(sof_a), 32'(e.sof));
        chk("eol", 32'(eol_a), 32'(e.eol));
        chk("meas_stb", 32'(meas_stb_a), 32'(e.stb));
        chk("meas_stb_b", 32'(meas_stb_b), 32'(e.stb));
        if (e.stb || e.chk_meas) begin
            chk("h_total", 32'(h_total_a), 32'(e.ht));
            chk("h_active", 32'(h_active_a), 32'(e.ha));
            chk("v_total", 32'(v_total_a), 32'(e.vt));
            chk("v_active", 32'(v_active_a), 32'(e.va));
            chk("frame_sum", frame_sum_a, e.sum);
            chk("locked", 32'(locked_a), 32'(e.locked));
            chk("h_total_b", 32'(h_total_b), 32'(e.ht));
            chk("v_total_b", 32'(v_total_b), 32'(e.vt));
            chk("frame_sum_b", frame_sum_b, e.sum);
            chk("locked_b", 32'(locked_b), 32'(e.locked));
        end
    endtask

    // One clock: drive inputs, then check what the input of one cycle earlier produced.
    task automatic step(input bit r, input bit h, input bit v, input bit d,
                        input logic [23:0] px, input exp_t e);
        rst = r; hs_a = ~h; vs_a = ~v; hs_b = h; vs_b = v; de = d; rgb = px;
        @(posedge clk_vid);
        #1;
        if (r) prev_e = zero_e();
        check_all(prev_e);
        prev_e = r ? zero_e() : e;
    endtask

    // Frame boundary as seen by the model: publish the last frame and track lock.
    task automatic frame_start(output bit stb);
        bit same;
        stb = 1'b0;
        if (m_state == 0) begin
            m_state = 1; m_match = 0; m_has_last = 1'b0;
        end else begin
            stb  = 1'b1;
            same = m_has_last && f_ht == last_ht && f_ha == last_ha &&
                   f_vt == last_vt && f_va == last_va;
            if (!same) begin
                m_state = 1; m_match = 0; m_locked = 1'b0;
            end else if (m_state == 1) begin
                m_match++;
                if (m_match == LOCK_N) begin
                    m_state = 2; m_locked = 1'b1;
                end
            end
            last_ht = f_ht; last_ha = f_ha; last_vt = f_vt; last_va = f_va;
            m_has_last = 1'b1;
            o_ht = f_ht; o_ha = f_ha; o_vt = f_vt; o_va = f_va; o_sum = f_sum;
        end
        m_vs_seen = 1'b1;
    endtask

    task automatic run_frame(input int htot, input int hact, input int vtot, input int vact,
                             input bit rnd, input int rst_line);
        bit [31:0] sum;
        sum = 32'd0;
        for (int l = 0; l < vtot; l++) begin
            for (int c = 0; c < htot; c++) begin
                exp_t        e;
                bit          h, v, d, r, stb;
                int          x, y;
                logic [23:0] px;
                h   = (c < 2);
                v   = (l < 2);
                d   = (l >= VSTART && l < VSTART + vact && c >= HSTART && c < HSTART + hact);
                r   = (l == rst_line && c == 0);
                x   = c - HSTART;
                y   = l - VSTART;
                px  = rnd ? 24'($urandom) : 24'(x + (y << 8));
                stb = 1'b0;
                if (l == 0 && c == 0) frame_start(stb);
                if (r) model_reset();
                if (d) sum += {8'h00, px};
                e       = base_e();
                e.valid = d;
                e.rgb   = px;
                e.x     = x;
                e.y     = m_vs_seen ? y : 0;
                e.sof   = d && x == 0 && e.y == 0;
                e.eol   = d && x == hact - 1;
                e.stb   = stb;
                step(r, h, v, d, px, e);
            end
        end
        f_ht = htot; f_ha = hact; f_vt = vtot; f_va = vact; f_sum = sum;
    endtask

    // Idle blanking; with expire set the gap outlasts the vs timeout.
    task automatic idle(input int n, input bit expire);
        exp_t e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, base_e());
        if (expire) begin
            m_state = 0; m_match = 0; m_has_last = 1'b0; m_locked = 1'b0;
            o_ht = 0; o_ha = 0; o_vt = 0; o_va = 0; o_sum = 32'd0;
            e = base_e();
            e.chk_meas = 1'b1;
            step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, e);
            step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, e);
        end
    endtask

    initial begin
        int ht, ha, vt, va;
        model_reset();
        f_ht = 0; f_ha = 0; f_vt = 0; f_va = 0; f_sum = 32'd0;
        last_ht = 0; last_ha = 0; last_vt = 0; last_va = 0;
        prev_e = zero_e();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, zero_e());

        // Small timing, rgb = x + (y << 8): lock at the fourth vs edge.
        repeat (5) run_frame(20, 8, 10, 4, 1'b0, -1);
        // One wider frame breaks lock, then re-lock.
        run_frame(20, 9, 10, 4, 1'b0, -1);
        repeat (4) run_frame(20, 8, 10, 4, 1'b0, -1);

        // Random timings, each repeated, random pixel data.
        for (int k = 0; k < 3; k++) begin
            ht = $urandom_range(24, 16);
            ha = $urandom_range(ht - 4, 4);
            vt = $urandom_range(12, 8);
            va = $urandom_range(vt - 2, 2);
            repeat (3) run_frame(ht, ha, vt, va, 1'b1, -1);
        end

        // vs disappears long enough to time out, then recover.
        idle(TO + 50, 1'b1);
        repeat (4) run_frame(20, 8, 10, 4, 1'b1, -1);

        // Reset in the middle of a locked frame.
        run_frame(20, 8, 10, 4, 1'b1, 5);
        repeat (3) run_frame(20, 8, 10, 4, 1'b1, -1);
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_in_monitor.md
Name: vid_in_monitor

Overview:
- Receive-side counterpart of the VDP video timing generator. Consumes a parallel RGB video stream (hs, vs, de, 24-bit RGB) on clk_vid.
- Recovers per-pixel x/y coordinates, frame and line markers, and measures frame timing (totals and active sizes).
- Runs a lock FSM and accumulates a per-frame pixel checksum.
- Sits at the input of a capture/scaler path; also serves as the loopback checker for the VDP output.

Parameters:
- SYNC_ACTIVE_LOW, 1, hs/vs asserted level is 0 when 1, else 1
- LOCK_FRAMES, 2, consecutive identical frame measurements required to assert locked (1..15)
- TIMEOUT, 2000000, clk_vid cycles without a vs leading edge before lock is dropped

Ports:
- clk_vid  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hs  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vs  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- de  in  1  data enable, active high
- rgb  in  24  {r,g,b} pixel, valid when de=1
- px_valid  out  1  output pixel valid
- px_rgb  out  24  pixel data
- px_x  out  12  column of current pixel
- px_y  out  12  row of current pixel
- sof  out  1  first pixel of frame (x=0, y=0)
- eol  out  1  last pixel of a line
- h_total  out  12  clocks per line (hs leading edge to hs leading edge)
- h_active  out  12  de-high clocks on last active line of frame
- v_total  out  12  hs leading edges per frame
- v_active  out  12  lines containing de=1 per frame
- frame_sum  out  32  mod-2^32 sum of {8'h00,rgb} over all de pixels of last frame
- locked  out  1  timing stable
- meas_stb  out  1  one-cycle pulse when measurement outputs update

Behaviour:
- Reset: all outputs 0; FSM = SEEK; all counters 0.
- Input stage: hs/vs/de/rgb registered once (s1), then again (s2). Edge detect on s1 versus s2 values after polarity normalisation.
- Pixel latency: a pixel sampled at cycle n appears on px_* at n+2.
- px_valid = s2 de. eol = px_valid && !s1 de, i.e. the next sample has de=0.
- px_x: 0 on the first de pixel of a line; +1 per de pixel.
- px_y: 0 on the first de line after a vs leading edge; +1 at each subsequent de rising edge. A de rising edge with no vs edge seen since reset leaves px_y at 0.
- sof = px_valid && px_x==0 && px_y==0.
- Coordinates and pixel outputs run regardless of lock state.
- Counters (line clock, de count, line count, active-line count) are 12 bits and saturate at 4095; no wrap. frame_sum accumulator wraps mod 2^32.
- Line timing:
  - hs leading edge latches the line clock count into h_total_work and restarts the count at 1.
  - de falling edge latches the de count into h_active_work.
- Frame boundary is the vs leading edge (normalised). On it:
  - v_total_work = hs edges since the previous vs edge.
  - v_active_work = de rising edges since the previous vs edge.
  - The sum accumulator is captured.
- FSM states:
  - SEEK: wait for a vs edge; discard partial counts; go to MEASURE, match_cnt=0.
  - MEASURE: at each vs edge, publish the work registers to the outputs and pulse meas_stb. If the published set equals the previous published set, match_cnt+1; else match_cnt=0. When match_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1 in the same cycle as meas_stb.
  - LOCKED: at each vs edge, publish and pulse meas_stb. Any mismatch sends the FSM to MEASURE with locked=0 and match_cnt=0.
  - First publish after SEEK always counts as a mismatch (no predecessor).
- Timeout: a free-running counter, cleared at each vs edge. When it reaches TIMEOUT in any state, go to SEEK: locked=0, measurement outputs and frame_sum cleared to 0, match_cnt=0.
- Simultaneous events:
  - vs and hs edges in the same cycle: the hs edge counts toward the closing frame, then the line counter resets.
  - vs edge while de=1: the pixel is summed into the new frame.
- rst mid-frame: immediate return to the reset state; no meas_stb.

Decomposition:
- Package vid_in_pkg holds:
  - the 12-bit coordinate/count typedef
  - a measurement struct {h_total, h_active, v_total, v_active}
  - the FSM state enum {SEEK, MEASURE, LOCKED}
  - the 640x480 reference constants (800/640/525/480) for benches
- One sub-module, vid_edge_sync: the two-stage input register, polarity normalisation and rise/fall pulse generation for hs/vs/de.

Test Plan:
- Standard 640x480 (800x525, hs/vs active low, constant rgb=0x404040), LOCK_FRAMES=2 -> first meas_stb at the second vs edge; locked=1 at the fourth vs edge; h_total=800, h_active=640, v_total=525, v_active=480, frame_sum=0x2D2C0000.
- Small timing 20x10 clocks, 8x4 active, rgb = x + (y<<8) -> px_x 0..7, px_y 0..3; sof once per frame at the first pixel, 2 cycles after its input; eol on x=7 each line; px_rgb matches input delayed 2 cycles.
- Locked on small timing, then one frame with h_active=9 -> meas_stb with locked=0 and h_active=9; re-locks after two further identical frames.
- Locked, then vs held inactive for TIMEOUT (override 100) cycles -> locked=0; all measurement outputs and frame_sum = 0; SEEK until the next vs edge.
- SYNC_ACTIVE_LOW=0 with inverted syncs -> identical measurements to the first scenario.
- rst pulsed mid-frame while locked -> next cycle all outputs 0; no meas_stb until two vs edges later.
